// File: rtl/seq_mul_div_32.sv
// Multi-cycle unsigned 32x32 multiplier / 32/32 divider sharing one ripple-carry adder/subtractor.
// Optional macro MULDIV_ZERO_SKIP_EN: multiplies with a zero operand finish without iterating.

module rc_add_sub_32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        sna,
    output logic [31:0] sum,
    output logic        co
);
    // Ripple-carry chain; sna inverts b and injects the +1 for a - b, so co=1 means no borrow
    always_comb begin
        logic [32:0] c;
        logic [31:0] bx;
        sum  = 32'h0000_0000;
        bx   = b ^ {32{sna}};
        c    = 33'h0_0000_0000;
        c[0] = sna;
        for (int i = 0; i < 32; i++) begin
            sum[i]   = a[i] ^ bx[i] ^ c[i];
            c[i + 1] = (a[i] & bx[i]) | (c[i] & (a[i] ^ bx[i]));
        end
        co = c[32];
    end
endmodule

module seq_mul_div_32 #(
    parameter int N_ITER = 32,
    parameter int CNT_W  = 5
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        START,
    input  logic        OP,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic        BUSY,
    output logic        DONE,
    output logic        ERR
);
    typedef enum logic {IDLE = 1'b0, CALC = 1'b1} state_t;

    state_t             state_r, state_s;
    logic [CNT_W-1:0]   cnt_r, cnt_s;
    logic               op_r, op_s;
    logic [31:0]        opd_r, opd_s;
    logic [31:0]        hi_r, hi_s;
    logic [31:0]        lo_r, lo_s;
    logic               busy_r, busy_s;
    logic               done_r, done_s;
    logic               err_r, err_s;

    logic [31:0]        add_a_s, add_b_s, sum_s;
    logic               add_sna_s, co_s;

    rc_add_sub_32 u_add (
        .a   (add_a_s),
        .b   (add_b_s),
        .sna (add_sna_s),
        .sum (sum_s),
        .co  (co_s)
    );

    // Adder operands: divide subtracts D from HI shifted left; multiply adds M when LO[0] is set
    always_comb begin
        if (op_r) begin
            add_a_s   = {hi_r[30:0], lo_r[31]};
            add_b_s   = opd_r;
            add_sna_s = 1'b1;
        end else begin
            add_a_s   = hi_r;
            add_b_s   = lo_r[0] ? opd_r : 32'h0000_0000;
            add_sna_s = 1'b0;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        op_s    = op_r;
        opd_s   = opd_r;
        hi_s    = hi_r;
        lo_s    = lo_r;
        err_s   = err_r;
        done_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (START) begin
                    op_s  = OP;
                    err_s = 1'b0;
                    cnt_s = {CNT_W{1'b0}};
                    if (OP && (B == 32'h0000_0000)) begin
                        hi_s   = A;
                        lo_s   = 32'hFFFF_FFFF;
                        err_s  = 1'b1;
                        done_s = 1'b1;
                    end
`ifdef MULDIV_ZERO_SKIP_EN
                    else if (!OP && ((A == 32'h0000_0000) || (B == 32'h0000_0000))) begin
                        hi_s   = 32'h0000_0000;
                        lo_s   = 32'h0000_0000;
                        done_s = 1'b1;
                    end
`endif
                    else begin
                        state_s = CALC;
                        hi_s    = 32'h0000_0000;
                        lo_s    = OP ? A : B;
                        opd_s   = OP ? B : A;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            CALC: begin
                cnt_s = cnt_r + CNT_W'(1);
                if (op_r) begin
                    // A set shifted-out bit means the partial remainder already exceeds D
                    if (hi_r[31] | co_s) begin
                        hi_s = sum_s;
                        lo_s = {lo_r[30:0], 1'b1};
                    end else begin
                        hi_s = {hi_r[30:0], lo_r[31]};
                        lo_s = {lo_r[30:0], 1'b0};
                    end
                end else begin
                    hi_s = {co_s, sum_s[31:1]};
                    lo_s = {sum_s[0], lo_r[31:1]};
                end
                if (cnt_r == CNT_W'(N_ITER - 1)) begin
                    state_s = IDLE;
                    done_s  = 1'b1;
                end else begin
                    state_s = CALC;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
        busy_s = (state_s == CALC);
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_r <= IDLE;
            cnt_r   <= {CNT_W{1'b0}};
            op_r    <= 1'b0;
            opd_r   <= 32'h0000_0000;
            hi_r    <= 32'h0000_0000;
            lo_r    <= 32'h0000_0000;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            err_r   <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            op_r    <= op_s;
            opd_r   <= opd_s;
            hi_r    <= hi_s;
            lo_r    <= lo_s;
            busy_r  <= busy_s;
            done_r  <= done_s;
            err_r   <= err_s;
        end
    end

    assign HI   = hi_r;
    assign LO   = lo_r;
    assign BUSY = busy_r;
    assign DONE = done_r;
    assign ERR  = err_r;
endmodule

// File: tb/tb_seq_mul_div_32.sv
// Directed scoreboard bench for seq_mul_div_32; honours MULDIV_ZERO_SKIP_EN for zero-operand latency.

module tb_seq_mul_div_32;
    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        START = 1'b0;
    logic        OP = 1'b0;
    logic [31:0] A = 32'h0;
    logic [31:0] B = 32'h0;
    logic [31:0] HI, LO;
    logic        BUSY, DONE, ERR;

    int checks = 0;
    int errors = 0;

`ifdef MULDIV_ZERO_SKIP_EN
    localparam int ZLAT = 0;
`else
    localparam int ZLAT = 32;
`endif

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        err;
    } exp_t;
    exp_t sbq[$];

    seq_mul_div_32 dut (
        .CLK   (CLK),
        .RST   (RST),
        .START (START),
        .OP    (OP),
        .A     (A),
        .B     (B),
        .HI    (HI),
        .LO    (LO),
        .BUSY  (BUSY),
        .DONE  (DONE),
        .ERR   (ERR)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic op, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        logic [63:0] p;
        if (!op) begin
            p     = {32'h0, a} * {32'h0, b};
            e.hi  = p[63:32];
            e.lo  = p[31:0];
            e.err = 1'b0;
        end else if (b == 32'h0) begin
            e.hi  = a;
            e.lo  = 32'hFFFF_FFFF;
            e.err = 1'b1;
        end else begin
            e.hi  = a % b;
            e.lo  = a / b;
            e.err = 1'b0;
        end
        return e;
    endfunction

    // Caller is at posedge+1; START is sampled at the next edge (edge N).
    task automatic run_op(input string tag, input logic op, input logic [31:0] a,
                          input logic [31:0] b, input int exp_lat, input int poke_at);
        int   lat;
        int   busy_cnt;
        exp_t e;
        sbq.push_back(model(op, a, b));
        OP = op; A = a; B = b; START = 1'b1;
        @(posedge CLK); #1;
        START = 1'b0;
        lat = 0;
        busy_cnt = 0;
        while (DONE !== 1'b1 && lat < 40) begin
            if (BUSY === 1'b1) busy_cnt++;
            if (lat == poke_at) begin
                START = 1'b1; OP = 1'b1; A = 32'd55; B = 32'd0;
            end else begin
                START = 1'b0;
            end
            @(posedge CLK); #1;
            lat++;
        end
        START = 1'b0;
        chk({tag, "_done"}, {63'h0, DONE}, 64'h1);
        chk({tag, "_latency"}, 64'(lat), 64'(exp_lat));
        chk({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(exp_lat));
        chk({tag, "_busy_at_done"}, {63'h0, BUSY}, 64'h0);
        e = sbq.pop_front();
        chk({tag, "_hi"}, {32'h0, HI}, {32'h0, e.hi});
        chk({tag, "_lo"}, {32'h0, LO}, {32'h0, e.lo});
        chk({tag, "_err"}, {63'h0, ERR}, {63'h0, e.err});
    endtask

    initial begin
        int pulses;
        logic [31:0] ra, rb;
        logic        rop;

        repeat (3) @(posedge CLK);
        #1;
        chk("reset_outputs", {31'h0, HI, LO, BUSY, DONE, ERR}, 64'h0);
        RST = 1'b1;
        @(posedge CLK); #1;

        run_op("mul_7x6", 1'b0, 32'd7, 32'd6, 32, -1);
        @(posedge CLK); #1;
        chk("mul_7x6_done_drop", {62'h0, DONE, BUSY}, 64'h0);
        chk("mul_7x6_hold", {HI, LO}, 64'd42);

        run_op("mul_max", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32, -1);
        chk("mul_max_exact", {HI, LO}, 64'hFFFF_FFFE_0000_0001);
        run_op("div_100_7", 1'b1, 32'd100, 32'd7, 32, -1);
        chk("div_100_7_exact", {HI, LO}, {32'd2, 32'd14});
        run_op("div_max_1", 1'b1, 32'hFFFF_FFFF, 32'd1, 32, -1);
        run_op("div_by_zero", 1'b1, 32'd5, 32'd0, 0, -1);
        chk("div_by_zero_exact", {HI, LO}, {32'd5, 32'hFFFF_FFFF});
        @(posedge CLK); #1;
        chk("div_by_zero_err_held", {62'h0, ERR, DONE}, 64'h2);

        // START pulsed on cycle 10 of a multiply must be ignored
        run_op("mul_3x4_poke", 1'b0, 32'd3, 32'd4, 32, 9);
        @(posedge CLK); #1;
        chk("poke_not_queued", {62'h0, BUSY, DONE}, 64'h0);

        // Reset on cycle 15 abandons the operation
        OP = 1'b0; A = 32'h0000_FFFF; B = 32'h0000_FFFF; START = 1'b1;
        @(posedge CLK); #1;
        START = 1'b0;
        repeat (14) @(posedge CLK);
        #1;
        RST = 1'b0;
        @(posedge CLK); #1;
        chk("midop_reset_outputs", {31'h0, HI, LO, BUSY, DONE, ERR}, 64'h0);
        RST = 1'b1;
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            if (DONE === 1'b1 || BUSY === 1'b1) pulses++;
            @(posedge CLK); #1;
        end
        chk("midop_reset_no_done", 64'(pulses), 64'h0);

        // Back-to-back: the second START lands in the DONE cycle of the first
        run_op("b2b_first", 1'b0, 32'h1234_5678, 32'h9ABC_DEF0, 32, -1);
        run_op("b2b_second", 1'b1, 32'hDEAD_BEEF, 32'h0000_1234, 32, -1);

        run_op("mul_zero_a", 1'b0, 32'd0, 32'd9, ZLAT, -1);
        run_op("mul_zero_b", 1'b0, 32'hCAFE_F00D, 32'd0, ZLAT, -1);
        run_op("div_small_by_big", 1'b1, 32'd3, 32'hFFFF_FFF0, 32, -1);

        for (int k = 0; k < 4; k++) begin
            ra  = $urandom;
            rb  = $urandom_range(1, 32'h7FFF_FFFF);
            rop = k[0];
            run_op($sformatf("rand%0d", k), rop, ra, rb, 32, -1);
        end

        chk("scoreboard_empty", 64'(sbq.size()), 64'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
